rc_drive_arm_ctrl: RTL and testbench

- Safety controller between the RF gamepad decoder and the servo/ESC PWM generators.
- Latches decoded frames and arms the ESC only after throttle is held at neutral.
- Slew-limits throttle while armed and forces neutral outputs on RF link loss.
- Drives the status LED with a pattern that encodes the current state.

---
 rtl/rc_drive_arm_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_rc_drive_arm_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rc_drive_arm_ctrl.sv
// rc_drive_arm_ctrl
// Safety controller between the RF gamepad decoder and the servo/ESC PWM
// generators. It latches decoded frames, arms the ESC only after throttle
// has been held at neutral for ARM_MS, slew-limits throttle while armed,
// forces neutral outputs when the RF link is lost, and drives a status LED
// whose pattern encodes the current state.
//
// Ports:
//   iCLK        system clock, all logic on the rising edge
//   iRESET      asynchronous, active-high reset
//   iRX_SERVO   decoded steering value
//   iRX_ESC     decoded throttle value
//   iRX_VALID   one-cycle strobe, iRX_SERVO/iRX_ESC carry a new frame
//   oSERVO_VAL  steering value to the servo PWM generator
//   oESC_VAL    throttle value to the ESC PWM generator
//   oARMED      high while armed
//   oFAILSAFE   high while in failsafe
//   oLED        status LED
module rc_drive_arm_ctrl #(
  parameter int TICK_DIV      = 48000,
  parameter int NEUTRAL       = 128,
  parameter int DEADBAND      = 4,
  parameter int ARM_MS        = 500,
  parameter int TIMEOUT_MS    = 100,
  parameter int SLEW_STEP     = 2,
  parameter int BLINK_SLOW_MS = 125,
  parameter int BLINK_FAST_MS = 50
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic [7:0] iRX_SERVO,
  input  logic [7:0] iRX_ESC,
  input  logic       iRX_VALID,
  output logic [7:0] oSERVO_VAL,
  output logic [7:0] oESC_VAL,
  output logic       oARMED,
  output logic       oFAILSAFE,
  output logic       oLED
);

  localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ARM_W     = $clog2(ARM_MS + 1);
  localparam int TO_W      = $clog2(TIMEOUT_MS + 1);
  localparam int BLINK_MAX = (BLINK_SLOW_MS > BLINK_FAST_MS) ? BLINK_SLOW_MS : BLINK_FAST_MS;
  localparam int BL_W      = $clog2(BLINK_MAX + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [7:0]         NEUT      = 8'(NEUTRAL);
  localparam logic [ARM_W-1:0]   ARM_MAX   = ARM_W'(ARM_MS);
  localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(TIMEOUT_MS);
  localparam logic [BL_W-1:0]    SLOW_P    = BL_W'(BLINK_SLOW_MS);
  localparam logic [BL_W-1:0]    FAST_P    = BL_W'(BLINK_FAST_MS);
  localparam logic [BL_W-1:0]    BL_SAT    = BL_W'(BLINK_MAX);
  localparam logic signed [8:0]  DB_S      = $signed(9'(DEADBAND));
  localparam logic signed [9:0]  STEP_S    = $signed(10'(SLEW_STEP));
  localparam logic [7:0]         STEP_U    = 8'(SLEW_STEP);

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_ARMING,
    ST_ARMED,
    ST_FAILSAFE
  } state_t;

  // |v - NEUTRAL| <= DEADBAND, evaluated in 9-bit signed so nothing wraps.
  function automatic logic is_neutral(input logic [7:0] v);
    logic signed [8:0] diff;
    diff = $signed({1'b0, v}) - $signed({1'b0, NEUT});
    if (diff < 0) diff = -diff;
    return (diff <= DB_S);
  endfunction

  // One slew step of cur toward tgt; lands exactly on tgt when within a step,
  // so the result always stays between cur and tgt and cannot wrap.
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [9:0] diff;
    diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
    if (diff > STEP_S)       return cur + STEP_U;
    else if (diff < -STEP_S) return cur - STEP_U;
    else                     return tgt;
  endfunction

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]        srv_q, srv_d;
  logic [7:0]        esc_q, esc_d;
  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [BL_W-1:0]   blink_q, blink_d;
  logic              led_q, led_d;
  logic [7:0]        servo_out_q, servo_out_d;
  logic [7:0]        esc_out_q, esc_out_d;

  logic              tick;
  logic              link_ok;
  logic              neutral;
  logic [BL_W-1:0]   period;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    srv_d     = srv_q;
    esc_d     = esc_q;
    timeout_d = timeout_q;
    // A new frame beats a coincident tick, so link loss can never be
    // declared on the same edge a frame arrives.
    if (iRX_VALID) begin
      srv_d     = iRX_SERVO;
      esc_d     = iRX_ESC;
      timeout_d = '0;
    end else if (tick && (timeout_q != TO_MAX)) begin
      timeout_d = timeout_q + TO_W'(1);
    end

    link_ok = (timeout_q < TO_MAX);
    neutral = is_neutral(esc_q);

    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    unique case (state_q)
      ST_DISARMED: begin
        if (link_ok && neutral) begin
          state_d   = ST_ARMING;
          arm_cnt_d = '0;
        end
      end
      ST_ARMING: begin
        // Link loss while arming only aborts; failsafe is reserved for ARMED.
        if (!neutral || !link_ok) begin
          state_d   = ST_DISARMED;
          arm_cnt_d = '0;
        end else if (tick) begin
          if (arm_cnt_q != ARM_MAX) arm_cnt_d = arm_cnt_q + ARM_W'(1);
          if (arm_cnt_d == ARM_MAX) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!link_ok) state_d = ST_FAILSAFE;
      end
      ST_FAILSAFE: begin
        if (link_ok) begin
          state_d   = ST_DISARMED;
          arm_cnt_d = '0;
        end
      end
      default: state_d = ST_DISARMED;
    endcase

    blink_d = blink_q;
    led_d   = led_q;
    period  = (state_q == ST_FAILSAFE) ? FAST_P : SLOW_P;
    if (state_d != state_q) begin
      blink_d = '0;
      led_d   = (state_d == ST_ARMED);
    end else begin
      unique case (state_q)
        ST_ARMING, ST_FAILSAFE: begin
          if (tick) begin
            if (blink_q != BL_SAT) blink_d = blink_q + BL_W'(1);
            if (blink_d >= period) begin
              blink_d = '0;
              led_d   = ~led_q;
            end
          end
        end
        ST_ARMED: led_d = 1'b1;
        default:  led_d = 1'b0;
      endcase
    end

    // Output values are chosen from the state being entered so failsafe
    // neutralisation takes effect on the entry edge without slewing.
    servo_out_d = NEUT;
    esc_out_d   = NEUT;
    unique case (state_d)
      ST_ARMED: begin
        servo_out_d = srv_q;
        esc_out_d   = (state_q == ST_ARMED && tick) ? slew(esc_out_q, esc_q) : esc_out_q;
      end
      ST_FAILSAFE: begin
        servo_out_d = NEUT;
        esc_out_d   = NEUT;
      end
      default: begin
        servo_out_d = link_ok ? srv_q : NEUT;
        esc_out_d   = NEUT;
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q     <= ST_DISARMED;
      tick_cnt_q  <= '0;
      srv_q       <= NEUT;
      esc_q       <= NEUT;
      timeout_q   <= TO_MAX;
      arm_cnt_q   <= '0;
      blink_q     <= '0;
      led_q       <= 1'b0;
      servo_out_q <= NEUT;
      esc_out_q   <= NEUT;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      srv_q       <= srv_d;
      esc_q       <= esc_d;
      timeout_q   <= timeout_d;
      arm_cnt_q   <= arm_cnt_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
      servo_out_q <= servo_out_d;
      esc_out_q   <= esc_out_d;
    end
  end

  assign oSERVO_VAL = servo_out_q;
  assign oESC_VAL   = esc_out_q;
  assign oARMED     = (state_q == ST_ARMED);
  assign oFAILSAFE  = (state_q == ST_FAILSAFE);
  assign oLED       = led_q;

endmodule

// File: tb/tb_rc_drive_arm_ctrl.sv
// Directed testbench for rc_drive_arm_ctrl with a 10-cycle tick, 5-tick
// arming, 8-tick link timeout and fast blink periods. All expected values
// are written out against the post-reset edge count cyc_cnt (ticks land on
// edges 10, 20, 30, ...).
module tb_rc_drive_arm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_srv, rx_esc;
  logic       rx_vld;
  logic [7:0] servo_val, esc_val;
  logic       armed, failsafe, led;

  int         cyc_cnt;
  int         checks = 0;
  int         errors = 0;

  bit         auto_en;
  logic [7:0] auto_esc, auto_srv;
  bit         frc;
  logic [7:0] frc_esc, frc_srv;

  rc_drive_arm_ctrl #(
    .TICK_DIV     (10),
    .NEUTRAL      (128),
    .DEADBAND     (4),
    .ARM_MS       (5),
    .TIMEOUT_MS   (8),
    .SLEW_STEP    (2),
    .BLINK_SLOW_MS(2),
    .BLINK_FAST_MS(1)
  ) dut (
    .iCLK      (clk),
    .iRESET    (rst),
    .iRX_SERVO (rx_srv),
    .iRX_ESC   (rx_esc),
    .iRX_VALID (rx_vld),
    .oSERVO_VAL(servo_val),
    .oESC_VAL  (esc_val),
    .oARMED    (armed),
    .oFAILSAFE (failsafe),
    .oLED      (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc_cnt <= 0;
    else     cyc_cnt <= cyc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, cyc_cnt, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, esc_val, servo_val, armed, failsafe, led};
  endfunction

  function automatic logic [31:0] pk(input int e, input int s, input int a, input int f, input int l);
    return {13'd0, 8'(e), 8'(s), 1'(a), 1'(f), 1'(l)};
  endfunction

  // One clock: stop at the falling edge, then drive this cycle's inputs.
  // Automatic frames are driven when cyc_cnt%30==2 and so latch on edges
  // congruent to 3 mod 30.
  task automatic cycle();
    @(negedge clk);
    rx_vld = 1'b0;
    if (frc) begin
      rx_vld = 1'b1;
      rx_esc = frc_esc;
      rx_srv = frc_srv;
      frc    = 1'b0;
    end else if (auto_en && (cyc_cnt % 30 == 2)) begin
      rx_vld = 1'b1;
      rx_esc = auto_esc;
      rx_srv = auto_srv;
    end
  endtask

  task automatic run_to(input int n);
    int guard = 0;
    while (cyc_cnt < n && guard < 5000) begin
      cycle();
      guard++;
    end
    if (cyc_cnt != n) check("run_to", 32'(cyc_cnt), 32'(n));
  endtask

  initial begin
    rst = 1'b1; rx_vld = 1'b0; rx_srv = 8'd0; rx_esc = 8'd0;
    auto_en = 1'b0; auto_esc = 8'd128; auto_srv = 8'd128;
    frc = 1'b0; frc_esc = 8'd128; frc_srv = 8'd128;

    repeat (2) @(negedge clk);
    check("reset_state", outs(), pk(128, 128, 0, 0, 0));
    rst = 1'b0;

    // Idle, no frames: link lost, outputs neutral.
    for (int i = 1; i <= 10; i++) begin
      run_to(20 * i);
      check("idle", outs(), pk(128, 128, 0, 0, 0));
    end

    // Frames esc=130 servo=90; first latches at 213, ARMING from 214.
    auto_esc = 8'd130; auto_srv = 8'd90; auto_en = 1'b1;
    run_to(213); check("srv_lat_1edge", 32'(servo_val), 32'd128);
    run_to(214); check("srv_lat_2edge", 32'(servo_val), 32'd90);
    run_to(235); check("arming_led_on", 32'(led), 32'd1);
    run_to(245); check("arming_led_hold", 32'(led), 32'd1);
    run_to(255); check("arming_led_off", 32'(led), 32'd0);
    run_to(259); check("not_yet_armed", 32'(armed), 32'd0);
    run_to(260); check("armed_5th_tick", 32'(armed), 32'd1);
    run_to(265); check("armed_entry", outs(), pk(128, 90, 1, 0, 1));
    run_to(275); check("esc_130", 32'(esc_val), 32'd130);

    // Slew up toward 137, then down to 0.
    auto_esc = 8'd128;
    run_to(305); check("esc_hold_130", 32'(esc_val), 32'd130);
    run_to(315); check("esc_back_128", 32'(esc_val), 32'd128);
    auto_esc = 8'd137;
    begin
      int up_exp [6] = '{130, 132, 134, 136, 137, 137};
      for (int k = 0; k < 6; k++) begin
        run_to(345 + 10 * k);
        check("slew_up", 32'(esc_val), 32'(up_exp[k]));
      end
    end
    auto_esc = 8'd0;
    for (int k = 0; k <= 70; k++) begin
      int e;
      e = 137 - 2 * (k + 1);
      if (e < 0) e = 0;
      run_to(435 + 10 * k);
      check("slew_down", 32'(esc_val), 32'(e));
    end
    check("armed_servo", 32'(servo_val), 32'd90);

    // Frames stop; last latched at 1113, 8th tick at 1190.
    auto_en = 1'b0;
    run_to(1190); check("pre_fs", outs(), pk(0, 90, 1, 0, 1));
    run_to(1191); check("fs_entry", outs(), pk(128, 128, 0, 1, 0));
    run_to(1205); check("fs_led_on", 32'(led), 32'd1);
    run_to(1215); check("fs_led_off", 32'(led), 32'd0);
    auto_esc = 8'd200; auto_en = 1'b1;
    run_to(1233); check("fs_hold", 32'(failsafe), 32'd1);
    run_to(1234); check("fs_exit", outs(), pk(128, 90, 0, 0, 0));
    run_to(1300); check("disarmed_200", outs(), pk(128, 90, 0, 0, 0));

    // Re-arm, abort with esc=140, then a fresh 5-tick count.
    auto_esc = 8'd128;
    run_to(1345); check("rearm_led", 32'(led), 32'd1);
    frc_esc = 8'd140; frc_srv = 8'd90; frc = 1'b1;
    run_to(1347); check("abort_pending", 32'(led), 32'd1);
    run_to(1348); check("abort_disarmed", outs(), pk(128, 90, 0, 0, 0));
    run_to(1375); check("no_stale_count", 32'(armed), 32'd0);
    run_to(1399); check("fresh_not_yet", 32'(armed), 32'd0);
    run_to(1400); check("fresh_armed", 32'(armed), 32'd1);

    // Slew toward 170, reset asynchronously while at 150.
    auto_esc = 8'd170;
    run_to(1515); check("slew_148", 32'(esc_val), 32'd148);
    run_to(1525); check("slew_150", 32'(esc_val), 32'd150);
    auto_en = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset", outs(), pk(128, 128, 0, 0, 0));
    repeat (2) @(negedge clk);
    check("reset_held", outs(), pk(128, 128, 0, 0, 0));
    rst = 1'b0;

    // Arm again, stop frames, then land a frame on the expiry tick (170).
    auto_esc = 8'd128; auto_srv = 8'd100; auto_en = 1'b1;
    run_to(49); check("rst_arm_wait", 32'(armed), 32'd0);
    run_to(50); check("rst_armed", 32'(armed), 32'd1);
    run_to(95); auto_en = 1'b0;
    run_to(168); check("pre_expiry", 32'(failsafe), 32'd0);
    frc_esc = 8'd128; frc_srv = 8'd100; frc = 1'b1;
    run_to(171); check("coincident_no_fs", outs(), pk(128, 100, 1, 0, 1));
    run_to(200); check("coincident_later", outs(), pk(128, 100, 1, 0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
